cordic_angle_fold: RTL and testbench

//  Front end of the CORDIC sin/cos datapath; the input-side counterpart of the octant un-fold output stage.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_delay_line.sv | 33 +++
 rtl/cordic_angle_fold.sv | 134 +++++++++++++
 tb/tb_cordic_angle_fold.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, octant type and the residual-angle fold helper for the CORDIC front end.
package cordic_pkg;

    localparam int PHASE_W_DEF = 16;
    localparam int WIDTH = 22;
    localparam logic [WIDTH-1:0] K_INIT = WIDTH'(636751);

    // pi/4 in datapath units (z0) and in phase units (fold residual)
    localparam logic [WIDTH-1:0] PI_4 = {3'b001, {(WIDTH-3){1'b0}}};
    localparam logic [PHASE_W_DEF-3:0] PI_4_PHASE = {1'b1, {(PHASE_W_DEF-3){1'b0}}};

    typedef logic [2:0] octant_t;

    // Odd octants run backwards, so mirror the residual about pi/4; lo = 0 yields exactly pi/4.
    function automatic logic [PHASE_W_DEF-3:0] fold_res(
        input logic                   odd,
        input logic [PHASE_W_DEF-4:0] lo
    );
        logic [PHASE_W_DEF-3:0] lo_ext;
        lo_ext = {1'b0, lo};
        return odd ? (PI_4_PHASE - lo_ext) : lo_ext;
    endfunction

endpackage

// File: rtl/cordic_delay_line.sv
// Generic DEPTH x W shift register, shifts every cycle; latency DEPTH cycles, no backpressure.
module cordic_delay_line #(
    parameter int DEPTH = 17,
    parameter int W     = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("cordic_delay_line: DEPTH must be at least 1");
    end

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/cordic_angle_fold.sv
// CORDIC front end: phase -> octant + [0, pi/4] residual; X0/Y0/Z0 after 2 cycles, octant MSB_DLY later; no backpressure.
// Optional CORDIC_NCO_EN replaces phase_in with an internal phase accumulator stepped by freq_word.
module cordic_angle_fold #(
    parameter int                 PHASE_W = cordic_pkg::PHASE_W_DEF,
    parameter int                 WIDTH   = cordic_pkg::WIDTH,
    parameter logic [WIDTH-1:0]   K_INIT  = cordic_pkg::K_INIT,
    parameter int                 MSB_DLY = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [PHASE_W-1:0] phase_in,
    input  logic [PHASE_W-1:0] freq_word,
    output logic               valid_out,
    output logic [WIDTH-1:0]   x0,
    output logic [WIDTH-1:0]   y0,
    output logic [WIDTH-1:0]   z0,
    output logic [2:0]         msb_out,
    output logic               msb_vld
);

    import cordic_pkg::*;

    if (PHASE_W != PHASE_W_DEF) begin : g_bad_phase_w
        $error("cordic_angle_fold: PHASE_W must match cordic_pkg::PHASE_W_DEF");
    end
    if (WIDTH != cordic_pkg::WIDTH) begin : g_bad_width
        $error("cordic_angle_fold: WIDTH must match cordic_pkg::WIDTH");
    end
    if (MSB_DLY < 1) begin : g_bad_dly
        $error("cordic_angle_fold: MSB_DLY must be at least 1");
    end

    logic [PHASE_W-1:0] w_phase;

    logic               r_s1_vld;
    logic [PHASE_W-1:0] r_s1_phase;

    octant_t            w_oct;
    logic [PHASE_W-4:0] w_lo;
    logic [PHASE_W-3:0] w_res;

    logic               r_vld;
    logic [WIDTH-1:0]   r_x0;
    logic [WIDTH-1:0]   r_y0;
    logic [WIDTH-1:0]   r_z0;
    octant_t            r_oct;

    logic [3:0]         w_dly_in;
    logic [3:0]         w_dly_out;

`ifdef CORDIC_NCO_EN
    logic [PHASE_W-1:0] r_acc;
    logic               w_unused_phase;

    // Each accepted sample sees the accumulator before this cycle's increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (valid_in) begin
            r_acc <= r_acc + freq_word;
        end
    end

    assign w_phase        = r_acc;
    assign w_unused_phase = ^phase_in;
`else
    logic               w_unused_freq;

    assign w_phase       = phase_in;
    assign w_unused_freq = ^freq_word;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_phase <= '0;
        end else begin
            r_s1_vld <= valid_in;
            if (valid_in) begin
                r_s1_phase <= w_phase;
            end
        end
    end

    assign w_oct = r_s1_phase[PHASE_W-1 -: 3];
    assign w_lo  = r_s1_phase[PHASE_W-4:0];
    assign w_res = fold_res(w_oct[0], w_lo);

    // Data registers hold on invalid cycles; only r_vld qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
            r_x0  <= '0;
            r_y0  <= '0;
            r_z0  <= '0;
            r_oct <= '0;
        end else begin
            r_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_x0  <= K_INIT;
                r_y0  <= '0;
                r_z0  <= {2'b00, w_res, {(WIDTH-PHASE_W){1'b0}}};
                r_oct <= w_oct;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_z0 <= PI_4);
        end
    end

    assign w_dly_in = {r_vld, r_oct};

    cordic_delay_line #(
        .DEPTH (MSB_DLY),
        .W     (4)
    ) u_msb_dly (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (w_dly_in),
        .o_q   (w_dly_out)
    );

    assign valid_out = r_vld;
    assign x0        = r_x0;
    assign y0        = r_y0;
    assign z0        = r_z0;
    assign msb_vld   = w_dly_out[3];
    assign msb_out   = w_dly_out[2:0];

endmodule

// File: tb/tb_cordic_angle_fold.sv
// Directed bench for cordic_angle_fold: fold table, octant sweep, valid toggling, reset with samples in flight.
module tb_cordic_angle_fold;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [15:0] phase_in;
    logic [15:0] freq_word;
    logic        valid_out;
    logic [21:0] x0;
    logic [21:0] y0;
    logic [21:0] z0;
    logic [2:0]  msb_out;
    logic        msb_vld;

    int total = 0;
    int bad   = 0;

    localparam logic [21:0] K_EXP = 22'd636751;

    typedef struct {
        logic [15:0] phase;
        logic [21:0] z0;
        logic [2:0]  oct;
    } vec_t;

    vec_t vecs [11];

    logic        s_vld   [32];
    logic [15:0] s_phase [32];
    logic [21:0] s_z0    [32];
    logic [2:0]  s_oct   [32];

    always #5 clk = ~clk;

    cordic_angle_fold dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .phase_in  (phase_in),
        .freq_word (freq_word),
        .valid_out (valid_out),
        .x0        (x0),
        .y0        (y0),
        .z0        (z0),
        .msb_out   (msb_out),
        .msb_vld   (msb_vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Drives s_* entries 0..n-1 on consecutive cycles; data due at +2, octant at +19.
    task automatic run_stream(input int n);
        for (int c = 0; c < n + 20; c++) begin
            if (c >= 2) begin
                int k;
                k = c - 2;
                if (k < n && s_vld[k]) begin
                    chk("stream valid_out", valid_out, 1);
                    chk("stream x0", x0, K_EXP);
                    chk("stream z0", z0, s_z0[k]);
                end else begin
                    chk("stream valid_out idle", valid_out, 0);
                end
            end
            if (c >= 19) begin
                int k;
                k = c - 19;
                if (k < n && s_vld[k]) begin
                    chk("stream msb_vld", msb_vld, 1);
                    chk("stream msb_out", msb_out, s_oct[k]);
                end else begin
                    chk("stream msb_vld idle", msb_vld, 0);
                end
            end
            if (c < n) begin
                valid_in = s_vld[c];
                phase_in = s_phase[c];
            end else begin
                valid_in = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        phase_in  = 16'h0000;
        freq_word = 16'h0000;

        vecs[0]  = '{16'h0000, 22'h000000, 3'd0};
        vecs[1]  = '{16'h2000, 22'h080000, 3'd1};
        vecs[2]  = '{16'h1FFF, 22'h07FFC0, 3'd0};
        vecs[3]  = '{16'h6800, 22'h060000, 3'd3};
        vecs[4]  = '{16'h4000, 22'h000000, 3'd2};
        vecs[5]  = '{16'hFFFF, 22'h000040, 3'd7};
        vecs[6]  = '{16'h8001, 22'h000040, 3'd4};
        vecs[7]  = '{16'hA000, 22'h080000, 3'd5};
        vecs[8]  = '{16'hC123, 22'h0048C0, 3'd6};
        vecs[9]  = '{16'h3000, 22'h040000, 3'd1};
        vecs[10] = '{16'hE001, 22'h07FFC0, 3'd7};

        repeat (3) tick();
        chk("reset valid_out", valid_out, 0);
        chk("reset x0", x0, 0);
        chk("reset y0", y0, 0);
        chk("reset z0", z0, 0);
        chk("reset msb_out", msb_out, 0);
        chk("reset msb_vld", msb_vld, 0);
        rst = 1'b0;
        repeat (2) tick();

`ifdef CORDIC_NCO_EN
        freq_word = 16'h4000;
        for (int k = 0; k < 8; k++) begin
            s_vld[k]   = 1'b1;
            s_phase[k] = 16'hFFFF;
            s_z0[k]    = 22'h000000;
            s_oct[k]   = 3'((k % 4) * 2);
        end
        run_stream(8);
`else
        for (int i = 0; i < 11; i++) begin
            phase_in = vecs[i].phase;
            valid_in = 1'b1;
            tick();
            valid_in = 1'b0;
            tick();
            chk("table valid_out", valid_out, 1);
            chk("table x0", x0, K_EXP);
            chk("table y0", y0, 0);
            chk("table z0", z0, vecs[i].z0);
            repeat (16) tick();
            chk("table msb_vld early", msb_vld, 0);
            tick();
            chk("table msb_vld", msb_vld, 1);
            chk("table msb_out", msb_out, vecs[i].oct);
            tick();
            chk("table msb_vld after", msb_vld, 0);
            chk("table z0 hold", z0, vecs[i].z0);
        end

        for (int k = 0; k < 8; k++) begin
            s_vld[k]   = 1'b1;
            s_phase[k] = {3'(k), 13'h0100};
            s_z0[k]    = (k % 2 == 1) ? 22'h07C000 : 22'h004000;
            s_oct[k]   = 3'(k);
        end
        run_stream(8);

        for (int k = 0; k < 12; k++) begin
            s_vld[k]   = (k % 2 == 0);
            s_phase[k] = vecs[k % 11].phase;
            s_z0[k]    = vecs[k % 11].z0;
            s_oct[k]   = vecs[k % 11].oct;
        end
        run_stream(12);
`endif

        for (int k = 0; k < 5; k++) begin
            phase_in = vecs[k + 1].phase;
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        chk("inflight valid_out", valid_out, 1);
        rst = 1'b1;
        #1;
        chk("async rst valid_out", valid_out, 0);
        chk("async rst x0", x0, 0);
        chk("async rst y0", y0, 0);
        chk("async rst z0", z0, 0);
        chk("async rst msb_out", msb_out, 0);
        chk("async rst msb_vld", msb_vld, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("post rst valid_out", valid_out, 0);
            chk("post rst msb_vld", msb_vld, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
